// File: rtl/search_key_sched_pkg.sv
// search_pkg: shared types and widths for the rule-search request stage.
// Optional statistics are enabled with the SEARCH_SCHED_STAT_EN macro.
package search_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } t_sched_state;

  localparam int unsigned TMO_CNT_W      = 16;
  localparam int unsigned STAT_ISSUED_W  = 32;
  localparam int unsigned STAT_TIMEOUT_W = 16;
  localparam int unsigned STAT_SPUR_W    = 16;

  // Pointer width for a power-of-two FIFO depth (never below 1 bit).
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/search_key_sched_key_fifo.sv
// key_fifo: synchronous FIFO holding search keys.
// Push when full and pop when empty are ignored; pointers wrap modulo DEPTH.
module key_fifo
  import search_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 24
) (
  input  logic                        clk_i,
  input  logic                        rstn_i,
  input  logic                        i_push,
  input  logic [WIDTH-1:0]            i_data,
  input  logic                        i_pop,
  output logic [WIDTH-1:0]            o_head,
  output logic [ptr_width(DEPTH):0]   o_count,
  output logic                        o_full,
  output logic                        o_empty
);

  localparam int unsigned PW = ptr_width(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  // Full is taken from the registered count, so a same-cycle pop never frees a slot for a push.
  assign o_full  = (r_count == FULL_CNT);
  assign o_empty = (r_count == '0);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_head  = r_mem[r_rptr];
  assign o_count = r_count;

  // Key storage write port; contents need no reset since occupancy gates reads.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_data;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/search_key_sched.sv
// search_key_sched: buffers search keys and issues them one at a time to the
// rule-search engine once every block RAM is ready and none is busy.
// Define SEARCH_SCHED_STAT_EN to add saturating issue/timeout/spurious-hit counters.
module search_key_sched
  import search_pkg::*;
#(
  parameter int unsigned C_NUM_TABLE  = 4,
  parameter int unsigned C_RULE_WIDTH = 24,
  parameter int unsigned C_FIFO_DEPTH = 8,
  parameter int unsigned C_TIMEOUT    = 255
) (
  input  logic                              clk_i,
  input  logic                              rstn_i,
  input  logic                              req_vd_i,
  input  logic [C_RULE_WIDTH-1:0]           req_key_i,
  output logic                              req_rdy_o,
  input  logic [C_NUM_TABLE-1:0]            ready_i,
  input  logic [C_NUM_TABLE-1:0]            busy_i,
  output logic                              search_o,
  output logic [C_RULE_WIDTH-1:0]           key_o,
  input  logic                              hit_vd_i,
  output logic                              done_o,
  output logic                              timeout_o,
  output logic [ptr_width(C_FIFO_DEPTH):0]  pending_o
`ifdef SEARCH_SCHED_STAT_EN
  ,
  output logic [STAT_ISSUED_W-1:0]          stat_issued_o,
  output logic [STAT_TIMEOUT_W-1:0]         stat_timeout_o,
  output logic [STAT_SPUR_W-1:0]            stat_spur_o
`endif
);

  localparam logic [TMO_CNT_W-1:0] TMO_LAST = TMO_CNT_W'(C_TIMEOUT - 1);

  t_sched_state                  r_state;
  logic                          r_search;
  logic [C_RULE_WIDTH-1:0]       r_key;
  logic [TMO_CNT_W-1:0]          r_tmo_cnt;

  logic [C_RULE_WIDTH-1:0]       w_head;
  logic [ptr_width(C_FIFO_DEPTH):0] w_count;
  logic                          w_full;
  logic                          w_empty;
  logic                          w_issue;
  logic                          w_in_wait;
  logic                          w_tmo_last;

  key_fifo #(
    .DEPTH (C_FIFO_DEPTH),
    .WIDTH (C_RULE_WIDTH)
  ) u_key_fifo (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .i_push  (req_vd_i),
    .i_data  (req_key_i),
    .i_pop   (w_issue),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Engine readiness is only looked at while idle.
  assign w_issue    = (r_state == IDLE) & ~w_empty & (&ready_i) & ~(|busy_i);
  assign w_in_wait  = (r_state == WAIT);
  assign w_tmo_last = (r_tmo_cnt == TMO_LAST);

  assign req_rdy_o  = ~w_full;
  assign pending_o  = w_count;
  assign search_o   = r_search;
  assign key_o      = r_key;
  // A hit in the final WAIT cycle takes precedence over the timeout.
  assign done_o     = w_in_wait & hit_vd_i;
  assign timeout_o  = w_in_wait & ~hit_vd_i & w_tmo_last;

  // Issue sequencer: one outstanding search, bounded by the timeout counter.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state   <= IDLE;
      r_search  <= 1'b0;
      r_key     <= '0;
      r_tmo_cnt <= '0;
    end else begin
      r_search <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_issue) begin
            r_state   <= ISSUE;
            r_search  <= 1'b1;
            r_key     <= w_head;
            r_tmo_cnt <= '0;
          end
        end
        ISSUE: begin
          r_state <= WAIT;
        end
        WAIT: begin
          if (hit_vd_i || w_tmo_last) begin
            r_state <= IDLE;
          end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

`ifdef SEARCH_SCHED_STAT_EN
  logic [STAT_ISSUED_W-1:0]  r_stat_issued;
  logic [STAT_TIMEOUT_W-1:0] r_stat_timeout;
  logic [STAT_SPUR_W-1:0]    r_stat_spur;
  logic                      w_spur;

  assign w_spur         = hit_vd_i & ~w_in_wait;
  assign stat_issued_o  = r_stat_issued;
  assign stat_timeout_o = r_stat_timeout;
  assign stat_spur_o    = r_stat_spur;

  // Saturating event counters.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_stat_issued  <= '0;
      r_stat_timeout <= '0;
      r_stat_spur    <= '0;
    end else begin
      if (w_issue && (r_stat_issued != '1)) begin
        r_stat_issued <= r_stat_issued + STAT_ISSUED_W'(1);
      end
      if (timeout_o && (r_stat_timeout != '1)) begin
        r_stat_timeout <= r_stat_timeout + STAT_TIMEOUT_W'(1);
      end
      if (w_spur && (r_stat_spur != '1)) begin
        r_stat_spur <= r_stat_spur + STAT_SPUR_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_search_key_sched.sv
// Bench for search_key_sched: transaction-level model plus directed scenarios.
// Build with SEARCH_SCHED_STAT_EN defined to also cover the statistics outputs.
module tb_search_key_sched;

  localparam int TMO   = 16;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        req_vd = 1'b0;
  logic [23:0] req_key = '0;
  logic        req_rdy;
  logic [3:0]  ready = 4'hF;
  logic [3:0]  busy = 4'h0;
  logic        search;
  logic [23:0] key;
  logic        hit = 1'b0;
  logic        done;
  logic        tmo;
  logic [3:0]  pending;
`ifdef SEARCH_SCHED_STAT_EN
  logic [31:0] st_issued;
  logic [15:0] st_tmo;
  logic [15:0] st_spur;
`endif

  int checks = 0;
  int errors = 0;

  search_key_sched #(
    .C_NUM_TABLE  (4),
    .C_RULE_WIDTH (24),
    .C_FIFO_DEPTH (DEPTH),
    .C_TIMEOUT    (TMO)
  ) dut (
    .clk_i     (clk),
    .rstn_i    (rstn),
    .req_vd_i  (req_vd),
    .req_key_i (req_key),
    .req_rdy_o (req_rdy),
    .ready_i   (ready),
    .busy_i    (busy),
    .search_o  (search),
    .key_o     (key),
    .hit_vd_i  (hit),
    .done_o    (done),
    .timeout_o (tmo),
    .pending_o (pending)
`ifdef SEARCH_SCHED_STAT_EN
    ,
    .stat_issued_o  (st_issued),
    .stat_timeout_o (st_tmo),
    .stat_spur_o    (st_spur)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A search is "outstanding" from its issue cycle (age 0) until it finishes;
  // ages >= 1 are the cycles in which the engine may answer.
  logic [23:0] m_q[$];
  bit          m_out = 0;
  int          m_age = 0;
  logic [23:0] m_key = '0;
  logic [31:0] m_issued = '0;
  logic [15:0] m_tmos = '0;
  logic [15:0] m_spur = '0;
  bit          m_push;
  bit          m_answerable;

  task automatic model_step();
    if (!rstn) begin
      m_q.delete();
      m_out = 0; m_age = 0; m_key = '0;
      m_issued = '0; m_tmos = '0; m_spur = '0;
    end else begin
      m_push       = req_vd && (m_q.size() < DEPTH);
      m_answerable = m_out && (m_age >= 1);
      if (hit && !m_answerable && m_spur != 16'hFFFF) m_spur++;
      if (m_out) begin
        if (m_answerable && hit) m_out = 0;
        else if (m_answerable && m_age == TMO) begin
          m_out = 0;
          if (m_tmos != 16'hFFFF) m_tmos++;
        end else m_age++;
      end else if (m_q.size() > 0 && ready == 4'hF && busy == 4'h0) begin
        m_key = m_q.pop_front();
        m_out = 1; m_age = 0;
        if (m_issued != 32'hFFFF_FFFF) m_issued++;
      end
      if (m_push) m_q.push_back(req_key);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    model_step();
  end

  // Every-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    chk("m_search", search, (m_out && m_age == 0));
    chk("m_key", key, m_key);
    chk("m_done", done, (m_out && m_age >= 1 && hit));
    chk("m_timeout", tmo, (m_out && m_age >= 1 && !hit && m_age == TMO));
    chk("m_pending", pending, m_q.size());
    chk("m_req_rdy", req_rdy, (m_q.size() < DEPTH));
`ifdef SEARCH_SCHED_STAT_EN
    chk("m_stat_issued", st_issued, m_issued);
    chk("m_stat_timeout", st_tmo, m_tmos);
    chk("m_stat_spur", st_spur, m_spur);
`endif
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_search(input int limit, output bit found);
    found = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (search) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
    end
    chk("search_wait", found, 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  bit found;

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_search", search, 1'b0);
    chk("rst_key", key, 24'h0);
    chk("rst_pending", pending, 4'd0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", tmo, 1'b0);
    tick(); rstn = 1'b1;
    tick();

    // Single key latency and completion
    req_vd = 1'b1; req_key = 24'hABCDEF;
    tick();                                   // edge N: key pushed
    req_vd = 1'b0;
    @(negedge clk);
    chk("lat_n_search", search, 1'b0);
    chk("lat_n_pending", pending, 4'd1);
    tick();
    @(negedge clk);
    chk("lat_n2_search", search, 1'b1);
    chk("lat_n2_key", key, 24'hABCDEF);
    tick();
    @(negedge clk);
    chk("lat_n3_search", search, 1'b0);
    tick(); tick();
    hit = 1'b1;
    @(negedge clk);
    chk("hit_done", done, 1'b1);
    chk("hit_timeout", tmo, 1'b0);
    chk("hit_pending", pending, 4'd0);
    tick(); hit = 1'b0;
    @(negedge clk);
    chk("post_hit_done", done, 1'b0);

    // Fill FIFO while engine blocked, ninth push dropped
    tick(); ready = 4'h7;
    for (int i = 0; i < 9; i++) begin
      req_vd = 1'b1; req_key = 24'h100000 + 24'(i);
      tick();
    end
    req_vd = 1'b0;
    @(negedge clk);
    chk("full_pending", pending, 4'd8);
    chk("full_req_rdy", req_rdy, 1'b0);
    chk("blocked_search", search, 1'b0);
    tick(); ready = 4'hF;
    for (int i = 0; i < 8; i++) begin
      wait_search(10, found);
      chk("order_key", key, 24'h100000 + 24'(i));
      tick(); hit = 1'b1;
      @(negedge clk);
      chk("order_done", done, 1'b1);
      tick(); hit = 1'b0;
    end
    repeat (5) tick();
    @(negedge clk);
    chk("drain_pending", pending, 4'd0);
    chk("drain_rdy", req_rdy, 1'b1);

    // Timeout in the 16th WAIT cycle, then next key issues
    tick();
    req_vd = 1'b1; req_key = 24'h0000A5; tick();
    req_key = 24'h00005A; tick();
    req_vd = 1'b0;
    wait_search(10, found);
    chk("tmo_key", key, 24'h0000A5);
    for (int k = 1; k <= TMO; k++) begin
      tick();
      @(negedge clk);
      if (k == TMO - 1) chk("tmo_early", tmo, 1'b0);
      if (k == TMO) chk("tmo_fire", tmo, 1'b1);
    end
    tick(); tick();
    @(negedge clk);
    chk("tmo_next_search", search, 1'b1);
    chk("tmo_next_key", key, 24'h00005A);

    // Hit coincident with the final timeout cycle
    repeat (TMO - 1) tick();
    tick(); hit = 1'b1;
    @(negedge clk);
    chk("race_done", done, 1'b1);
    chk("race_timeout", tmo, 1'b0);
    tick(); hit = 1'b0;

    // Busy blocks issue; release; then reset during WAIT
    tick(); busy = 4'h2;
    req_vd = 1'b1; req_key = 24'h111111; tick();
    req_key = 24'h222222; tick();
    req_vd = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("busy_no_search", search, 1'b0);
      tick();
    end
    busy = 4'h0;
    found = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      if (search) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("unbusy_issue", found, 1'b1);
    chk("unbusy_key", key, 24'h111111);
    tick(); tick();
    hit = 1'b1;
    rstn = 1'b0;
    #1;
    chk("arst_search", search, 1'b0);
    chk("arst_done", done, 1'b0);
    chk("arst_timeout", tmo, 1'b0);
    chk("arst_key", key, 24'h0);
    chk("arst_pending", pending, 4'd0);
    hit = 1'b0;
    tick(); rstn = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    chk("arst_dropped_pending", pending, 4'd0);
    chk("arst_no_search", search, 1'b0);

    // 2 spurious hits, then 3 hits and 1 timeout
    tick();
    hit = 1'b1; tick(); hit = 1'b0; tick();
    hit = 1'b1; tick(); hit = 1'b0; tick();
    @(negedge clk);
    chk("spur_done", done, 1'b0);
    tick(); busy = 4'h2;
    for (int i = 0; i < 4; i++) begin
      req_vd = 1'b1; req_key = 24'h300001 + 24'(i);
      tick();
    end
    req_vd = 1'b0; busy = 4'h0;
    for (int i = 0; i < 4; i++) begin
      wait_search(10, found);
      chk("stat_key", key, 24'h300001 + 24'(i));
      if (i < 3) begin
        tick(); hit = 1'b1;
        @(negedge clk);
        chk("stat_done", done, 1'b1);
        tick(); hit = 1'b0;
      end else begin
        repeat (TMO) tick();
        @(negedge clk);
        chk("stat_timeout_pulse", tmo, 1'b1);
        tick();
      end
    end
    repeat (3) tick();
    @(negedge clk);
`ifdef SEARCH_SCHED_STAT_EN
    chk("stat_issued", st_issued, 32'd4);
    chk("stat_timeout", st_tmo, 16'd1);
    chk("stat_spur", st_spur, 16'd2);
`endif
    chk("end_pending", pending, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/search_key_sched.md
Name: search_key_sched

Overview:
- Upstream request stage for the rule-search engine.
- Buffers incoming search keys in a small FIFO.
- Issues one search strobe plus key to the engine only when every block RAM reports ready and none reports busy.
- Allows only one search outstanding. It waits for hit_vd_i, or a timeout, before issuing the next key.

Parameters:
- C_NUM_TABLE, 4, number of block RAMs (1,2,4,8,16); width of ready_i and busy_i.
- C_RULE_WIDTH, 24, key bit width.
- C_FIFO_DEPTH, 8, key FIFO depth; power of two, minimum 2.
- C_TIMEOUT, 255, maximum WAIT cycles before the search is abandoned; range 2..65535.

Ports:
- clk_i  in  1  single clock; all logic is on the rising edge.
- rstn_i  in  1  asynchronous reset, active-low.
- req_vd_i  in  1  key request valid.
- req_key_i  in  C_RULE_WIDTH  key to search.
- req_rdy_o  out  1  FIFO can accept; a push occurs on req_vd_i & req_rdy_o.
- ready_i  in  C_NUM_TABLE  per-RAM ready.
- busy_i  in  C_NUM_TABLE  per-RAM busy.
- search_o  out  1  one-cycle search strobe to the engine.
- key_o  out  C_RULE_WIDTH  key presented with search_o; held until the next issue.
- hit_vd_i  in  1  engine search-finished strobe.
- done_o  out  1  pulse: outstanding search completed by hit_vd_i.
- timeout_o  out  1  pulse: outstanding search abandoned.
- pending_o  out  $clog2(C_FIFO_DEPTH)+1  FIFO occupancy.

Behaviour:
- Reset (asynchronous, rstn_i=0):
  - FSM goes to IDLE; FIFO is emptied.
  - All of the following clear to 0: search_o, done_o, timeout_o, key_o, pending_o, timeout counter.
  - req_rdy_o=1 once rstn_i=1.
  - Reset mid-search drops the outstanding search and all queued keys.
- FIFO:
  - req_rdy_o = (pending_o < C_FIFO_DEPTH); it depends only on registered occupancy.
  - A pop in the same cycle does not open a slot for a push when full.
  - Simultaneous push and pop when not full leaves pending_o unchanged.
  - Read and write pointers wrap modulo C_FIFO_DEPTH.
  - A push while full is ignored and the key is lost; this is the sender's fault and needs no flag.
- FSM states are IDLE, ISSUE and WAIT.
  - IDLE -> ISSUE when FIFO is non-empty, &ready_i=1 and |busy_i=0. On that edge: pop the head into key_o, clear the timeout counter.
  - ISSUE: search_o=1 for exactly this cycle. Go to WAIT unconditionally. hit_vd_i is ignored here.
  - WAIT: on hit_vd_i=1, done_o=1 this cycle and go to IDLE.
  - WAIT: otherwise increment the counter. If the counter reaches C_TIMEOUT-1, timeout_o=1 this cycle and go to IDLE.
  - hit_vd_i and the timeout in the same cycle: the hit wins, so done_o=1 and timeout_o=0.
- Output timing:
  - search_o is a registered decode of state==ISSUE.
  - done_o and timeout_o are combinational from the WAIT state and inputs.
- Latency:
  - A key accepted at edge N into an empty FIFO with the engine ready gives search_o high during cycle N+2.
  - Back-to-back throughput: IDLE, ISSUE, >=1 WAIT cycle, so at best one search per 3 cycles.
- hit_vd_i in IDLE or ISSUE is ignored and raises no output.
- ready_i or busy_i changing during ISSUE or WAIT has no effect. They are sampled only in IDLE.

Optional Feature:
- Macro SEARCH_SCHED_STAT_EN.
- When defined, add outputs:
  - stat_issued_o (32 bit): increments on each ISSUE entry.
  - stat_timeout_o (16 bit): increments on each timeout_o.
  - stat_spur_o (16 bit): increments on hit_vd_i outside WAIT.
- All counters saturate at all-ones and reset to 0.
- When not defined, these ports and counters do not exist; core behaviour is identical.

Decomposition:
- Package search_pkg holds:
  - state enum t_sched_state {IDLE, ISSUE, WAIT};
  - a localparam function for pointer width from C_FIFO_DEPTH;
  - stat counter widths.
- Sub-module key_fifo: parameterised synchronous FIFO with push, pop, head, count and full/empty. The FSM, timeout counter and stats stay in search_key_sched.

Test Plan:
- Reset, then one key 0xABCDEF pushed at edge N with ready_i=4'hF, busy_i=0 -> search_o high only in cycle N+2 with key_o=0xABCDEF. Then hit_vd_i 3 cycles later -> done_o=1 that cycle, pending_o=0.
- Push 8 keys with engine blocked (ready_i=4'h7) -> pending_o=8, req_rdy_o=0, a 9th push is ignored. Release ready_i=4'hF -> 8 searches issued in push order, each following the previous hit_vd_i.
- Outstanding search, no hit_vd_i, C_TIMEOUT=16 -> timeout_o=1 in the 16th WAIT cycle, then the next key issues.
- hit_vd_i coincident with the final timeout cycle -> done_o=1, timeout_o=0.
- busy_i=4'h2 while keys are queued -> no search_o. Clear busy_i -> issue within 2 cycles. Assert rstn_i=0 during WAIT -> all outputs 0 immediately and FIFO empty.
- With SEARCH_SCHED_STAT_EN: 3 hits, 1 timeout, 2 spurious hit_vd_i in IDLE -> stat_issued_o=4, stat_timeout_o=1, stat_spur_o=2.
